decimal_entry: RTL and testbench

- Input-side counterpart of the binary-to-BCD/seven-segment display path: turns decimal numbers typed on a PS/2 keyboard into an 8-bit binary operand.
- Consumes already-framed scancode bytes and accumulates up to three BCD digits plus a sign.
- On Enter, converts the digits to binary with a multi-cycle multiply-by-ten loop and range-checks the result.
- Delivers a one-cycle-validated value to the register updater in place of the switch inputs.

---
 rtl/decimal_entry_pkg.sv | 46 ++++
 rtl/decimal_entry_scancode_to_bcd.sv | 40 ++++
 rtl/decimal_entry.sv | 226 ++++++++++++++++++++++
 tb/tb_decimal_entry.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decimal_entry_pkg.sv
// Shared constants and types for the keyboard decimal-entry path.
package decimal_entry_pkg;

    // Digit buffer depth for an 8-bit result (up to three decimal digits)
    localparam int MAX_DIGITS = 3;

    // PS/2 set 2 make codes for the number row
    localparam logic [7:0] KC_0 = 8'h45;
    localparam logic [7:0] KC_1 = 8'h16;
    localparam logic [7:0] KC_2 = 8'h1E;
    localparam logic [7:0] KC_3 = 8'h26;
    localparam logic [7:0] KC_4 = 8'h25;
    localparam logic [7:0] KC_5 = 8'h2E;
    localparam logic [7:0] KC_6 = 8'h36;
    localparam logic [7:0] KC_7 = 8'h3D;
    localparam logic [7:0] KC_8 = 8'h3E;
    localparam logic [7:0] KC_9 = 8'h46;

    // Editing and framing codes
    localparam logic [7:0] KC_ENTER = 8'h5A;
    localparam logic [7:0] KC_MINUS = 8'h4E;
    localparam logic [7:0] KC_BKSP  = 8'h66;
    localparam logic [7:0] KC_ESC   = 8'h76;
    localparam logic [7:0] KC_BREAK = 8'hF0;
    localparam logic [7:0] KC_EXT   = 8'hE0;

    // Controller states: collect keys, convert digits, commit/reject
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Command class of a decoded scancode byte
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_DIGIT = 3'd1,
        CMD_BKSP  = 3'd2,
        CMD_MINUS = 3'd3,
        CMD_ESC   = 3'd4,
        CMD_ENTER = 3'd5,
        CMD_BREAK = 3'd6,
        CMD_EXT   = 3'd7
    } cmd_e;

endpackage

// File: rtl/decimal_entry_scancode_to_bcd.sv
// Combinational classifier: scancode byte -> BCD digit and command class.
module scancode_to_bcd
    import decimal_entry_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] digit,
    output logic       is_digit,
    output cmd_e       cmd
);

    // Decode the byte; anything unrecognised is CMD_NONE
    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b0;
        cmd      = CMD_NONE;
        case (code)
            KC_0:     begin digit = 4'd0; is_digit = 1'b1; end
            KC_1:     begin digit = 4'd1; is_digit = 1'b1; end
            KC_2:     begin digit = 4'd2; is_digit = 1'b1; end
            KC_3:     begin digit = 4'd3; is_digit = 1'b1; end
            KC_4:     begin digit = 4'd4; is_digit = 1'b1; end
            KC_5:     begin digit = 4'd5; is_digit = 1'b1; end
            KC_6:     begin digit = 4'd6; is_digit = 1'b1; end
            KC_7:     begin digit = 4'd7; is_digit = 1'b1; end
            KC_8:     begin digit = 4'd8; is_digit = 1'b1; end
            KC_9:     begin digit = 4'd9; is_digit = 1'b1; end
            KC_ENTER: cmd = CMD_ENTER;
            KC_MINUS: cmd = CMD_MINUS;
            KC_BKSP:  cmd = CMD_BKSP;
            KC_ESC:   cmd = CMD_ESC;
            KC_BREAK: cmd = CMD_BREAK;
            KC_EXT:   cmd = CMD_EXT;
            default:  cmd = CMD_NONE;
        endcase
        if (is_digit) begin
            cmd = CMD_DIGIT;
        end
    end

endmodule

// File: rtl/decimal_entry.sv
// Keyboard decimal entry: collects up to three typed digits plus a sign,
// converts them to an 8-bit binary value on Enter and range-checks it.
module decimal_entry
#(
    parameter int MAX_DIGITS  = 3,
    parameter int SIGNED_MODE = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic [7:0]  value,
    output logic        value_valid,
    output logic        range_err,
    output logic        busy,
    output logic [11:0] bcd_echo,
    output logic        neg,
    output logic [1:0]  digit_cnt
);
    import decimal_entry_pkg::*;

    localparam logic [1:0] CNT_MAX   = 2'(MAX_DIGITS);
    localparam logic [1:0] STEP_LAST = 2'(MAX_DIGITS - 1);

    // Magnitude limit depends on sign and on the signed/unsigned build
    function automatic logic in_range(input logic [9:0] mag, input logic is_neg);
        if (is_neg) begin
            return mag <= 10'd128;
        end else if (SIGNED_MODE != 0) begin
            return mag <= 10'd127;
        end else begin
            return mag <= 10'd255;
        end
    endfunction

    // Two's-complement negation of the magnitude; -0 naturally yields 0
    function automatic logic [7:0] apply_sign(input logic [9:0] mag, input logic is_neg);
        if (is_neg) begin
            return 8'(10'd0 - mag);
        end else begin
            return 8'(mag);
        end
    endfunction

    state_e      state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic [7:0]  value_q, value_d;
    logic        vv_q, vv_d;
    logic        re_q, re_d;
    logic [1:0]  step_q, step_d;
    logic [9:0]  acc_q, acc_d;

    logic [3:0]  key_digit;
    logic        key_is_digit;
    cmd_e        key_cmd;
    logic [3:0]  cur_digit;
    logic [9:0]  acc_mul;
    logic [9:0]  acc_nx;

    scancode_to_bcd u_dec (
        .code     (scan_code),
        .digit    (key_digit),
        .is_digit (key_is_digit),
        .cmd      (key_cmd)
    );

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            value_q <= '0;
            vv_q    <= 1'b0;
            re_q    <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            value_q <= value_d;
            vv_q    <= vv_d;
            re_q    <= re_d;
            step_q  <= step_d;
        end
    end

    // Conversion accumulator; always cleared on Enter before use, so no reset
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_valid && !brk_q && key_cmd == CMD_ENTER) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (step_q == STEP_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Most significant held digit first; missing leading digits read as 0
    always_comb begin
        case (step_q)
            2'd0:    cur_digit = bcd_q[11:8];
            2'd1:    cur_digit = bcd_q[7:4];
            default: cur_digit = bcd_q[3:0];
        endcase
        acc_mul = (acc_q << 3) + (acc_q << 1);
        acc_nx  = acc_mul + {6'd0, cur_digit};
    end

    // Key editing, conversion steps and commit of the result
    always_comb begin
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        value_d = value_q;
        vv_d    = 1'b0;
        re_d    = 1'b0;
        step_d  = step_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_valid) begin
                    if (brk_q) begin
                        // Released key: discard this byte
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        case (key_cmd)
                            CMD_BREAK: brk_d = 1'b1;
                            CMD_EXT:   ext_d = 1'b1;
                            CMD_DIGIT: begin
                                ext_d = 1'b0;
                                if (cnt_q < CNT_MAX) begin
                                    bcd_d = {bcd_q[7:0], key_digit};
                                    cnt_d = cnt_q + 2'd1;
                                end
                            end
                            CMD_BKSP: begin
                                ext_d = 1'b0;
                                if (cnt_q != 2'd0) begin
                                    bcd_d = {4'd0, bcd_q[11:4]};
                                    cnt_d = cnt_q - 2'd1;
                                end
                            end
                            CMD_MINUS: begin
                                ext_d = 1'b0;
                                if (SIGNED_MODE != 0) begin
                                    neg_d = !neg_q;
                                end
                            end
                            CMD_ESC: begin
                                ext_d = 1'b0;
                                bcd_d = '0;
                                cnt_d = '0;
                                neg_d = 1'b0;
                            end
                            CMD_ENTER: begin
                                brk_d  = 1'b0;
                                ext_d  = 1'b0;
                                acc_d  = '0;
                                step_d = '0;
                            end
                            default: ext_d = 1'b0;
                        endcase
                    end
                end
            end
            ST_CONV: begin
                acc_d  = acc_nx;
                step_d = step_q + 2'd1;
                if (step_q == STEP_LAST) begin
                    // Final digit folded in: commit or reject, then clear the entry
                    if (in_range(acc_nx, neg_q)) begin
                        value_d = apply_sign(acc_nx, neg_q);
                        vv_d    = 1'b1;
                    end else begin
                        re_d = 1'b1;
                    end
                    bcd_d = '0;
                    cnt_d = '0;
                    neg_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs: busy covers CONV and the CHECK cycle where the pulse is shown
    always_comb begin
        busy        = (state_q != ST_IDLE);
        value       = value_q;
        value_valid = vv_q;
        range_err   = re_q;
        bcd_echo    = bcd_q;
        neg         = neg_q;
        digit_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_decimal_entry.sv
// Scoreboard bench for decimal_entry: signed and unsigned instances.
module tb_decimal_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  scan_code = 8'h00;
    logic        sv_s = 1'b0;
    logic        sv_u = 1'b0;

    logic [7:0]  value_s, value_u;
    logic        vv_s, vv_u, re_s, re_u, busy_s, busy_u, neg_s, neg_u;
    logic [11:0] bcd_s, bcd_u;
    logic [1:0]  cnt_s, cnt_u;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        bit         err;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    exp_t e_s, e_u;

    decimal_entry #(.MAX_DIGITS(3), .SIGNED_MODE(1)) dut (
        .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(sv_s),
        .value(value_s), .value_valid(vv_s), .range_err(re_s), .busy(busy_s),
        .bcd_echo(bcd_s), .neg(neg_s), .digit_cnt(cnt_s)
    );

    decimal_entry #(.MAX_DIGITS(3), .SIGNED_MODE(0)) dut_u (
        .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(sv_u),
        .value(value_u), .value_valid(vv_u), .range_err(re_u), .busy(busy_u),
        .bcd_echo(bcd_u), .neg(neg_u), .digit_cnt(cnt_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit to_s, input bit to_u);
        scan_code = b;
        sv_s = to_s;
        sv_u = to_u;
        @(posedge clk);
        #1;
        sv_s = 1'b0;
        sv_u = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected pulse for an Enter strobed in the current cycle: 4 cycles later
    task automatic expect_s(input bit err, input logic [7:0] v);
        exp_t e;
        e.err = err; e.val = v; e.cyc = cyc + 4;
        q_s.push_back(e);
    endtask

    task automatic expect_u(input bit err, input logic [7:0] v);
        exp_t e;
        e.err = err; e.val = v; e.cyc = cyc + 4;
        q_u.push_back(e);
    endtask

    // Monitor for the signed instance
    always @(negedge clk) begin
        if (!rst) begin
            if (vv_s && re_s) begin
                checks++; fails++;
                $display("FAIL s_pulse_exclusive valid=1 err=1 required not both (cycle %0d)", cyc);
            end else if (vv_s || re_s) begin
                checks++;
                if (q_s.size() == 0) begin
                    fails++;
                    $display("FAIL s_unexpected_pulse valid=%0b err=%0b value=%02h (cycle %0d)", vv_s, re_s, value_s, cyc);
                end else begin
                    e_s = q_s.pop_front();
                    if (re_s != e_s.err || value_s !== e_s.val || cyc != e_s.cyc) begin
                        fails++;
                        $display("FAIL s_result got err=%0b value=%02h cycle=%0d expected err=%0b value=%02h cycle=%0d",
                                 re_s, value_s, cyc, e_s.err, e_s.val, e_s.cyc);
                    end
                end
            end else if (q_s.size() > 0 && cyc > q_s[0].cyc) begin
                checks++; fails++;
                e_s = q_s.pop_front();
                $display("FAIL s_missing_pulse got none expected err=%0b value=%02h at cycle %0d", e_s.err, e_s.val, e_s.cyc);
            end
        end
    end

    // Monitor for the unsigned instance
    always @(negedge clk) begin
        if (!rst) begin
            if (vv_u && re_u) begin
                checks++; fails++;
                $display("FAIL u_pulse_exclusive valid=1 err=1 required not both (cycle %0d)", cyc);
            end else if (vv_u || re_u) begin
                checks++;
                if (q_u.size() == 0) begin
                    fails++;
                    $display("FAIL u_unexpected_pulse valid=%0b err=%0b value=%02h (cycle %0d)", vv_u, re_u, value_u, cyc);
                end else begin
                    e_u = q_u.pop_front();
                    if (re_u != e_u.err || value_u !== e_u.val || cyc != e_u.cyc) begin
                        fails++;
                        $display("FAIL u_result got err=%0b value=%02h cycle=%0d expected err=%0b value=%02h cycle=%0d",
                                 re_u, value_u, cyc, e_u.err, e_u.val, e_u.cyc);
                    end
                end
            end else if (q_u.size() > 0 && cyc > q_u[0].cyc) begin
                checks++; fails++;
                e_u = q_u.pop_front();
                $display("FAIL u_missing_pulse got none expected err=%0b value=%02h at cycle %0d", e_u.err, e_u.val, e_u.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_value", value_s, 8'h00);
        chk("rst_bcd", bcd_s, 12'h000);
        chk("rst_cnt", cnt_s, 2'd0);
        chk("rst_busy", busy_s, 1'b0);
        chk("rst_neg", neg_s, 1'b0);
        chk("rst_pulses", {vv_s, re_s}, 2'b00);

        // 123 Enter -> 0x7B
        send(8'h16, 1, 0); send(8'h1E, 1, 0); send(8'h26, 1, 0);
        chk("echo_123", bcd_s, 12'h123);
        chk("cnt_123", cnt_s, 2'd3);
        expect_s(0, 8'h7B); send(8'h5A, 1, 0);
        chk("busy_after_enter", busy_s, 1'b1);
        idle(5);
        chk("cnt_after_commit", cnt_s, 2'd0);
        chk("bcd_after_commit", bcd_s, 12'h000);
        chk("busy_done", busy_s, 1'b0);

        // -128 commits 0x80, -129 is rejected with the value held
        send(8'h4E, 1, 0); send(8'h16, 1, 0); send(8'h1E, 1, 0); send(8'h3E, 1, 0);
        chk("neg_set", neg_s, 1'b1);
        chk("echo_128", bcd_s, 12'h128);
        expect_s(0, 8'h80); send(8'h5A, 1, 0); idle(5);
        send(8'h4E, 1, 0); send(8'h16, 1, 0); send(8'h1E, 1, 0); send(8'h46, 1, 0);
        expect_s(1, 8'h80); send(8'h5A, 1, 0); idle(5);
        chk("value_held_m129", value_s, 8'h80);
        chk("neg_cleared", neg_s, 1'b0);

        // 255: rejected in signed mode, committed in unsigned mode
        send(8'h1E, 1, 1); send(8'h2E, 1, 1); send(8'h2E, 1, 1);
        expect_s(1, 8'h80); expect_u(0, 8'hFF); send(8'h5A, 1, 1); idle(5);
        chk("u_value_255", value_u, 8'hFF);
        chk("s_value_kept", value_s, 8'h80);

        // Break drops the repeated 1, backspace removes 2 -> 13
        send(8'h16, 1, 0); send(8'hF0, 1, 0); send(8'h16, 1, 0);
        send(8'h1E, 1, 0); send(8'h66, 1, 0); send(8'h26, 1, 0);
        chk("echo_13", bcd_s, 12'h013);
        chk("cnt_13", cnt_s, 2'd2);
        expect_s(0, 8'h0D); send(8'h5A, 1, 0); idle(5);

        // Fourth digit ignored -> 111
        send(8'h16, 1, 0); send(8'h16, 1, 0); send(8'h16, 1, 0); send(8'h16, 1, 0);
        chk("echo_111", bcd_s, 12'h111);
        chk("cnt_full", cnt_s, 2'd3);
        expect_s(0, 8'h6F); send(8'h5A, 1, 0); idle(5);

        // 4 Enter, a digit during busy is dropped, keypad Enter on empty commits 0
        send(8'h25, 1, 0);
        expect_s(0, 8'h04); send(8'h5A, 1, 0);
        send(8'h16, 1, 0);
        idle(5);
        chk("busy_drop_bcd", bcd_s, 12'h000);
        chk("busy_drop_cnt", cnt_s, 2'd0);
        send(8'hE0, 1, 0);
        expect_s(0, 8'h00); send(8'h5A, 1, 0); idle(5);

        // Esc clears digits and sign; backspace on empty stays empty; -5
        send(8'h16, 1, 0); send(8'h4E, 1, 0); send(8'h76, 1, 0);
        chk("esc_bcd", bcd_s, 12'h000);
        chk("esc_neg", neg_s, 1'b0);
        send(8'h66, 1, 0);
        chk("bksp_empty_cnt", cnt_s, 2'd0);
        send(8'h4E, 1, 0); send(8'h2E, 1, 0);
        expect_s(0, 8'hFB); send(8'h5A, 1, 0); idle(5);

        // Reset in the middle of a conversion aborts it
        send(8'h3E, 1, 0); send(8'h3E, 1, 0); send(8'h5A, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_value", value_s, 8'h00);
        chk("midrst_busy", busy_s, 1'b0);
        chk("midrst_bcd", bcd_s, 12'h000);
        chk("midrst_cnt", cnt_s, 2'd0);
        chk("midrst_pulses", {vv_s, re_s}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        send(8'h25, 1, 0);
        expect_s(0, 8'h04); send(8'h5A, 1, 0); idle(6);

        chk("s_queue_drained", q_s.size(), 0);
        chk("u_queue_drained", q_u.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
